regfile_shadow: RTL and testbench

//   Parametrised double-buffered register file for DDS control words (tuning word, phase offset, amplitude).

---
 rtl/regfile_shadow_pkg.sv | 10 +
 rtl/regfile_shadow_bank.sv | 37 +++
 rtl/regfile_shadow.sv | 121 ++++++++++++
 tb/tb_regfile_shadow.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_shadow_pkg.sv
// Shared types for the DDS control-word register file: commit FSM states and
// read-bank selector encodings.
package dds_reg_pkg;

  typedef enum logic {CS_IDLE = 1'b0, CS_ARMED = 1'b1} commit_state_t;

  localparam logic BANK_SHADOW = 1'b0;
  localparam logic BANK_ACTIVE = 1'b1;

endpackage

// File: rtl/regfile_shadow_bank.sv
// One bank of DEPTH x DATA_W flops with async clear, a single-word write port
// and a whole-bank parallel load; contents are exposed flattened.
module reg_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic [ADDR_W-1:0]       i_waddr,
  input  logic [DATA_W-1:0]       i_wdata,
  input  logic                    i_load,
  input  logic [DEPTH*DATA_W-1:0] i_load_data,
  output logic [DEPTH*DATA_W-1:0] o_flat
);

  logic [DEPTH*DATA_W-1:0] r_mem;

  // Parallel load wins over a word write; out-of-range addresses match no word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
    end else if (i_load) begin
      r_mem <= i_load_data;
    end else if (i_we) begin
      for (int n = 0; n < DEPTH; n++) begin
        if (i_waddr == ADDR_W'(n)) begin
          r_mem[n*DATA_W +: DATA_W] <= i_wdata;
        end
      end
    end
  end

  assign o_flat = r_mem;

endmodule

// File: rtl/regfile_shadow.sv
// Double-buffered DDS control-word register file: host writes go to the shadow
// bank, a commit (optionally held until i_sync) copies it to the active bank.
module regfile_shadow
  import dds_reg_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter bit SYNC_COMMIT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en_wr,
  input  logic [ADDR_W-1:0]       i_addr_wr,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_en_rd,
  input  logic [ADDR_W-1:0]       i_addr_rd,
  input  logic                    i_rd_bank,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_rd_valid,
  input  logic                    i_commit,
  input  logic                    i_sync,
  output logic                    o_pending,
  output logic                    o_commit_done,
  output logic [DEPTH*DATA_W-1:0] o_active
);

  logic [DEPTH*DATA_W-1:0] w_shadow;
  logic [DEPTH*DATA_W-1:0] w_active;
  logic [DEPTH*DATA_W-1:0] w_merged;
  logic [DATA_W-1:0]       w_rd_word;
  logic                    w_copy;
  commit_state_t           w_state_nxt;
  commit_state_t           r_state;
  logic [DATA_W-1:0]       r_data;
  logic                    r_rd_valid;
  logic                    r_done;

  reg_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_shadow (
    .clk(clk), .rst(rst),
    .i_we(i_en_wr), .i_waddr(i_addr_wr), .i_wdata(i_data),
    .i_load(1'b0), .i_load_data({(DEPTH*DATA_W){1'b0}}),
    .o_flat(w_shadow)
  );

  reg_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_active (
    .clk(clk), .rst(rst),
    .i_we(1'b0), .i_waddr({ADDR_W{1'b0}}), .i_wdata({DATA_W{1'b0}}),
    .i_load(w_copy), .i_load_data(w_merged),
    .o_flat(w_active)
  );

  // Shadow contents as they will be after this edge: feeds both copy and write-first reads.
  always_comb begin
    w_merged = w_shadow;
    for (int n = 0; n < DEPTH; n++) begin
      w_merged[n*DATA_W +: DATA_W] = (i_en_wr && (i_addr_wr == ADDR_W'(n))) ?
                                     i_data : w_shadow[n*DATA_W +: DATA_W];
    end
  end

  // OR-reduced read mux; an unmatched (out-of-range) address yields zero.
  always_comb begin
    w_rd_word = '0;
    for (int n = 0; n < DEPTH; n++) begin
      w_rd_word |= (i_addr_rd == ADDR_W'(n)) ?
                   ((i_rd_bank == BANK_ACTIVE) ? w_active[n*DATA_W +: DATA_W]
                                               : w_merged[n*DATA_W +: DATA_W])
                   : {DATA_W{1'b0}};
    end
  end

  // Commit FSM next state and copy strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_copy      = 1'b0;
    if (!SYNC_COMMIT) begin
      w_copy      = i_commit;
      w_state_nxt = CS_IDLE;
    end else begin
      case (r_state)
        CS_IDLE: begin
          w_copy      = i_commit & i_sync;
          w_state_nxt = (i_commit & ~i_sync) ? CS_ARMED : CS_IDLE;
        end
        CS_ARMED: begin
          w_copy      = i_sync;
          w_state_nxt = i_sync ? CS_IDLE : CS_ARMED;
        end
        default: begin
          w_copy      = 1'b0;
          w_state_nxt = CS_IDLE;
        end
      endcase
    end
  end

  // State, done pulse and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CS_IDLE;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= w_copy;
      r_rd_valid <= i_en_rd;
      if (i_en_rd) begin
        r_data <= w_rd_word;
      end
    end
  end

  assign o_data        = r_data;
  assign o_rd_valid    = r_rd_valid;
  assign o_pending     = (r_state == CS_ARMED);
  assign o_commit_done = r_done;
  assign o_active      = w_active;

endmodule

// File: tb/tb_regfile_shadow.sv
// Self-checking bench: scoreboarded model for the default configuration, plus
// directed checks for an immediate-commit 32x16 build and a non-power-of-2 depth.
module tb_regfile_shadow;
  import dds_reg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // DUT A: defaults (8x8, sync commit)
  logic       a_en_wr, a_en_rd, a_rd_bank, a_commit, a_sync;
  logic [2:0] a_addr_wr, a_addr_rd;
  logic [7:0] a_data, a_o_data;
  logic       a_o_valid, a_pending, a_done;
  logic [63:0] a_active;

  regfile_shadow u_a (
    .clk(clk), .rst(rst), .i_en_wr(a_en_wr), .i_addr_wr(a_addr_wr), .i_data(a_data),
    .i_en_rd(a_en_rd), .i_addr_rd(a_addr_rd), .i_rd_bank(a_rd_bank), .o_data(a_o_data),
    .o_rd_valid(a_o_valid), .i_commit(a_commit), .i_sync(a_sync), .o_pending(a_pending),
    .o_commit_done(a_done), .o_active(a_active)
  );

  // DUT B: immediate commit, 32-bit x 16
  logic        b_en_wr, b_en_rd, b_rd_bank, b_commit, b_sync;
  logic [3:0]  b_addr_wr, b_addr_rd;
  logic [31:0] b_data, b_o_data;
  logic        b_o_valid, b_pending, b_done;
  logic [511:0] b_active;

  regfile_shadow #(.DATA_W(32), .DEPTH(16), .SYNC_COMMIT(1'b0)) u_b (
    .clk(clk), .rst(rst), .i_en_wr(b_en_wr), .i_addr_wr(b_addr_wr), .i_data(b_data),
    .i_en_rd(b_en_rd), .i_addr_rd(b_addr_rd), .i_rd_bank(b_rd_bank), .o_data(b_o_data),
    .o_rd_valid(b_o_valid), .i_commit(b_commit), .i_sync(b_sync), .o_pending(b_pending),
    .o_commit_done(b_done), .o_active(b_active)
  );

  // DUT C: DEPTH=6 so addresses 6 and 7 are out of range
  logic       c_en_wr, c_en_rd, c_rd_bank, c_commit, c_sync;
  logic [2:0] c_addr_wr, c_addr_rd;
  logic [7:0] c_data, c_o_data;
  logic       c_o_valid, c_pending, c_done;
  logic [47:0] c_active;

  regfile_shadow #(.DATA_W(8), .DEPTH(6)) u_c (
    .clk(clk), .rst(rst), .i_en_wr(c_en_wr), .i_addr_wr(c_addr_wr), .i_data(c_data),
    .i_en_rd(c_en_rd), .i_addr_rd(c_addr_rd), .i_rd_bank(c_rd_bank), .o_data(c_o_data),
    .o_rd_valid(c_o_valid), .i_commit(c_commit), .i_sync(c_sync), .o_pending(c_pending),
    .o_commit_done(c_done), .o_active(c_active)
  );

  // Reference model of DUT A
  logic [7:0] m_sh [8];
  logic [7:0] m_act [8];
  logic       m_armed, m_done, m_valid;
  logic [7:0] m_data;
  logic [7:0] exp_q [$];

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int k = 0; k < 8; k++) f[k*8 +: 8] = m_act[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_sh[k]  = 8'h00;
      m_act[k] = 8'h00;
    end
    m_armed = 1'b0;
    m_done  = 1'b0;
    m_valid = 1'b0;
    m_data  = 8'h00;
    exp_q.delete();
  endtask

  task automatic cyc_a(input string tag, input logic wr, input logic [2:0] wa, input logic [7:0] wd,
                       input logic rd, input logic [2:0] ra, input logic bk,
                       input logic cm, input logic sy);
    logic copy;
    a_en_wr = wr; a_addr_wr = wa; a_data = wd;
    a_en_rd = rd; a_addr_rd = ra; a_rd_bank = bk;
    a_commit = cm; a_sync = sy;
    if (rd) exp_q.push_back(bk ? m_act[ra] : ((wr && wa == ra) ? wd : m_sh[ra]));
    if (wr) m_sh[wa] = wd;
    copy    = m_armed ? sy : (cm && sy);
    m_armed = m_armed ? !sy : (cm && !sy);
    if (copy) for (int k = 0; k < 8; k++) m_act[k] = m_sh[k];
    m_done  = copy;
    m_valid = rd;
    @(posedge clk); #1;
    if (m_valid) begin
      if (exp_q.size() == 0) check_val({tag, "_q_empty"}, 64'd0, 64'd1);
      else m_data = exp_q.pop_front();
    end
    check_val({tag, "_rd_valid"}, {63'd0, a_o_valid}, {63'd0, m_valid});
    check_val({tag, "_rd_data"},  {56'd0, a_o_data},  {56'd0, m_data});
    check_val({tag, "_pending"},  {63'd0, a_pending}, {63'd0, m_armed});
    check_val({tag, "_done"},     {63'd0, a_done},    {63'd0, m_done});
    check_val({tag, "_active"},   a_active,           model_flat());
  endtask

  task automatic idle_a(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) cyc_a(tag, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    a_en_wr = 1'b0; a_addr_wr = 3'd0; a_data = 8'h00; a_en_rd = 1'b0; a_addr_rd = 3'd0;
    a_rd_bank = 1'b0; a_commit = 1'b0; a_sync = 1'b0;
    b_en_wr = 1'b0; b_addr_wr = 4'd0; b_data = 32'h0; b_en_rd = 1'b0; b_addr_rd = 4'd0;
    b_rd_bank = 1'b0; b_commit = 1'b0; b_sync = 1'b0;
    c_en_wr = 1'b0; c_addr_wr = 3'd0; c_data = 8'h00; c_en_rd = 1'b0; c_addr_rd = 3'd0;
    c_rd_bank = 1'b0; c_commit = 1'b0; c_sync = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_a_data",    {56'd0, a_o_data},  64'd0);
    check_val("rst_a_valid",   {63'd0, a_o_valid}, 64'd0);
    check_val("rst_a_pending", {63'd0, a_pending}, 64'd0);
    check_val("rst_a_done",    {63'd0, a_done},    64'd0);
    check_val("rst_a_active",  a_active,           64'd0);
    check_val("rst_b_active15", {32'd0, b_active[15*32 +: 32]}, 64'd0);
    rst = 1'b0;

    // 1: write + commit with sync high
    cyc_a("t1_wr",     1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc_a("t1_commit", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    idle_a("t1_after", 1);

    // 2: armed commit, write while armed, ignored re-commit, sync later
    cyc_a("t2_arm",    1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    cyc_a("t2_wr",     1'b1, 3'd0, 8'h11, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc_a("t2_recmt",  1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    idle_a("t2_wait", 2);
    cyc_a("t2_sync",   1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    idle_a("t2_after", 1);

    // 3: write-first shadow read, active read before/at/after commit
    cyc_a("t3_wfirst", 1'b1, 3'd2, 8'h3C, 1'b1, 3'd2, BANK_SHADOW, 1'b0, 1'b0);
    cyc_a("t3_act0",   1'b0, 3'd0, 8'h00, 1'b1, 3'd2, BANK_ACTIVE, 1'b0, 1'b0);
    cyc_a("t3_hold",   1'b0, 3'd0, 8'h00, 1'b0, 3'd5, BANK_SHADOW, 1'b0, 1'b0);
    cyc_a("t3_precmt", 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, BANK_ACTIVE, 1'b1, 1'b1);
    cyc_a("t3_b2b",    1'b1, 3'd7, 8'h5A, 1'b1, 3'd2, BANK_ACTIVE, 1'b1, 1'b1);
    cyc_a("t3_rd7",    1'b0, 3'd0, 8'h00, 1'b1, 3'd7, BANK_ACTIVE, 1'b0, 1'b0);

    // 5: async reset while armed with nonzero banks
    cyc_a("t5_arm",    1'b1, 3'd4, 8'hC3, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_val("t5_async_data",    {56'd0, a_o_data},  64'd0);
    check_val("t5_async_pending", {63'd0, a_pending}, 64'd0);
    check_val("t5_async_done",    {63'd0, a_done},    64'd0);
    check_val("t5_async_active",  a_active,           64'd0);
    rst = 1'b0;
    cyc_a("t5_sync",   1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    cyc_a("t5_shrd",   1'b0, 3'd0, 8'h00, 1'b1, 3'd4, BANK_SHADOW, 1'b0, 1'b0);

    // 4: out-of-range write/read on DEPTH=6
    c_en_wr = 1'b1; c_addr_wr = 3'd6; c_data = 8'hFF;
    c_en_rd = 1'b1; c_addr_rd = 3'd6; c_rd_bank = BANK_SHADOW;
    c_commit = 1'b1; c_sync = 1'b1;
    @(posedge clk); #1;
    check_val("t4_oob_data",   {56'd0, c_o_data},  64'd0);
    check_val("t4_oob_valid",  {63'd0, c_o_valid}, 64'd1);
    check_val("t4_oob_active", {16'd0, c_active},  64'd0);
    check_val("t4_oob_done",   {63'd0, c_done},    64'd1);
    c_addr_wr = 3'd5; c_data = 8'h77; c_addr_rd = 3'd5; c_commit = 1'b0; c_sync = 1'b0;
    @(posedge clk); #1;
    check_val("t4_in_data", {56'd0, c_o_data}, 64'h77);
    c_en_wr = 1'b0; c_addr_rd = 3'd7; c_rd_bank = BANK_ACTIVE;
    @(posedge clk); #1;
    check_val("t4_oob7_data",  {56'd0, c_o_data},  64'd0);
    check_val("t4_oob7_valid", {63'd0, c_o_valid}, 64'd1);
    c_en_rd = 1'b0;

    // 6: immediate commit, 32-bit x 16
    b_en_wr = 1'b1; b_addr_wr = 4'd15; b_data = 32'hDEADBEEF; b_commit = 1'b1; b_sync = 1'b0;
    @(posedge clk); #1;
    check_val("t6_act15",   {32'd0, b_active[15*32 +: 32]}, 64'hDEADBEEF);
    check_val("t6_done",    {63'd0, b_done},    64'd1);
    check_val("t6_pending", {63'd0, b_pending}, 64'd0);
    b_addr_wr = 4'd0; b_data = 32'h00001234; b_commit = 1'b0; b_sync = 1'b1;
    @(posedge clk); #1;
    check_val("t6_sync_act0", {32'd0, b_active[31:0]}, 64'd0);
    check_val("t6_sync_done", {63'd0, b_done},    64'd0);
    check_val("t6_sync_pend", {63'd0, b_pending}, 64'd0);
    b_en_wr = 1'b0; b_commit = 1'b1; b_sync = 1'b0;
    b_en_rd = 1'b1; b_addr_rd = 4'd15; b_rd_bank = BANK_ACTIVE;
    @(posedge clk); #1;
    check_val("t6_act0",  {32'd0, b_active[31:0]}, 64'h00001234);
    check_val("t6_rd15",  {32'd0, b_o_data},  64'hDEADBEEF);
    check_val("t6_done2", {63'd0, b_done},    64'd1);
    b_commit = 1'b0; b_en_rd = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
